// File: rtl/sram_march_bist.sv
// sram_march_bist
// March C- self-test sequencer for the 1RW port (port 0) of an OpenRAM
// 32-bit macro. It writes and reads every word in the March C- order,
// checks each read against the data background, and reports the results.
//
// Ports
//   la_sram_clk   single clock, shared with the macro's clk0
//   reset         synchronous, active-high
//   start         starts a run when sampled high in IDLE or DONE
//   stop_on_fail  end the run at the first miscompare (sampled at start)
//   pattern       data background; ~pattern is the inverse background
//   busy/done     run in progress / run finished (done is a level)
//   pass          valid while done: no miscompares
//   fail_count    saturating miscompare count
//   fail_addr/fail_elem/fail_data  first miscompare record
//   csb0/web0/wmask0/addr0/din0    SRAM port-0 controls and write data
//   dout0         SRAM port-0 read data
//
// Element order: E0 up(w0), E1 up(r0,w1), E2 up(r1,w0), E3 down(r0,w1),
// E4 down(r1,w0), E5 up(r0). In a read-write element, each address runs
// RD, RD_LAT cycles of RWAIT, then WR. The read data is compared on the
// edge that ends the last RWAIT cycle.
module sram_march_bist #(
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          la_sram_clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop_on_fail,
  input  logic [31:0]   pattern,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [15:0]   fail_count,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [31:0]   fail_data,
  output logic          csb0,
  output logic          web0,
  output logic [3:0]    wmask0,
  output logic [AW-1:0] addr0,
  output logic [31:0]   din0,
  input  logic [31:0]   dout0
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RWAIT, S_DONE} state_t;

  localparam logic [AW-1:0] ADDR_MAX = '1;
  localparam logic [2:0]    ELEM_LAST = 3'd5;

  state_t        state, state_nxt;
  logic [2:0]    elem;
  logic [AW-1:0] addr;
  logic [1:0]    wcnt;
  logic [31:0]   pat_q;
  logic          stop_q;

  logic          up, last_addr, wait_last, cmp_fire, miscmp, start_ok;
  logic [31:0]   exp_rd, wr_data;

  // Elements E3 and E4 walk the address space downwards.
  function automatic logic elem_up(input logic [2:0] e);
    return !(e == 3'd3 || e == 3'd4);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign up        = elem_up(elem);
  assign last_addr = up ? (addr == ADDR_MAX) : (addr == '0);
  // r1 happens in E2/E4, w1 in E1/E3; all other accesses use the plain background.
  assign exp_rd    = (elem == 3'd2 || elem == 3'd4) ? ~pat_q : pat_q;
  assign wr_data   = (elem == 3'd1 || elem == 3'd3) ? ~pat_q : pat_q;
  assign wait_last = (wcnt == 2'(RD_LAT - 1));
  assign cmp_fire  = (state == S_RWAIT) && wait_last;
  assign miscmp    = cmp_fire && (dout0 != exp_rd);
  assign start_ok  = (state == S_IDLE || state == S_DONE) && start;

  // State register
  always_ff @(posedge la_sram_clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_WR;
      // Only E0 goes from a write straight to another write. Every other
      // element begins each address with a read.
      S_WR:           state_nxt = (elem == 3'd0 && !last_addr) ? S_WR : S_RD;
      S_RD:           state_nxt = S_RWAIT;
      S_RWAIT: begin
        if (wait_last) begin
          if (miscmp && stop_q)      state_nxt = S_DONE;
          else if (elem == ELEM_LAST) state_nxt = last_addr ? S_DONE : S_RD;
          else                        state_nxt = S_WR;
        end
      end
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy   = (state == S_WR) || (state == S_RD) || (state == S_RWAIT);
    done   = (state == S_DONE);
    pass   = (state == S_DONE) && (fail_count == 16'd0);
    csb0   = !((state == S_WR) || (state == S_RD));
    web0   = (state != S_WR);
    wmask0 = (state == S_WR) ? 4'hF : 4'h0;
    addr0  = addr;
    din0   = (state == S_WR) ? wr_data : 32'd0;
  end

  // Address, element, wait counter and result registers
  always_ff @(posedge la_sram_clk) begin
    if (reset) begin
      elem       <= 3'd0;
      addr       <= '0;
      wcnt       <= 2'd0;
      fail_count <= 16'd0;
      fail_addr  <= '0;
      fail_elem  <= 3'd0;
      fail_data  <= 32'd0;
    end else begin
      if (start_ok) begin
        elem       <= 3'd0;
        addr       <= '0;
        fail_count <= 16'd0;
        fail_addr  <= '0;
        fail_elem  <= 3'd0;
        fail_data  <= 32'd0;
      end
      case (state)
        S_WR: begin
          if (last_addr) begin
            elem <= elem + 3'd1;
            addr <= elem_up(elem + 3'd1) ? '0 : ADDR_MAX;
          end else begin
            addr <= up ? addr + 1'b1 : addr - 1'b1;
          end
        end
        S_RD:    wcnt <= 2'd0;
        S_RWAIT: begin
          wcnt <= wcnt + 2'd1;
          // E5 has no write, so the address advances after the compare.
          if (wait_last && elem == ELEM_LAST && !last_addr) addr <= addr + 1'b1;
        end
        default: ;
      endcase
      if (miscmp) begin
        fail_count <= sat_inc16(fail_count);
        // The count is cleared at start and never wraps to zero, so zero
        // marks the first miscompare of the run.
        if (fail_count == 16'd0) begin
          fail_addr <= addr;
          fail_elem <= elem;
          fail_data <= dout0;
        end
      end
    end
  end

  // Run configuration, captured when a start is accepted
  always_ff @(posedge la_sram_clk) begin
    if (start_ok) begin
      pat_q  <= pattern;
      stop_q <= stop_on_fail;
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Testbench for sram_march_bist (AW=2, RD_LAT=1). A behavioural SRAM with an
// optional single-bit stuck-at fault sits on port 0. A reference model walks
// the March C- elements with plain loops and produces the expected port
// activity for every cycle and the expected result registers.
module tb_sram_march_bist;

  localparam int AW     = 2;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset, start, stop_on_fail;
  logic [31:0]   pattern;
  logic          busy, done, pass;
  logic [15:0]   fail_count;
  logic [AW-1:0] fail_addr;
  logic [2:0]    fail_elem;
  logic [31:0]   fail_data;
  logic          csb0, web0;
  logic [3:0]    wmask0;
  logic [AW-1:0] addr0;
  logic [31:0]   din0;
  logic [31:0]   dout0 = 32'd0;

  always #5 clk = ~clk;

  sram_march_bist #(.AW(AW), .RD_LAT(RD_LAT)) dut (
    .la_sram_clk (clk),
    .reset       (reset),
    .start       (start),
    .stop_on_fail(stop_on_fail),
    .pattern     (pattern),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_count  (fail_count),
    .fail_addr   (fail_addr),
    .fail_elem   (fail_elem),
    .fail_data   (fail_data),
    .csb0        (csb0),
    .web0        (web0),
    .wmask0      (wmask0),
    .addr0       (addr0),
    .din0        (din0),
    .dout0       (dout0)
  );

  // Fault configuration shared by the SRAM model and the reference model
  logic          fault_en;
  logic [AW-1:0] fault_addr;
  int            fault_bit;
  logic          fault_val;

  function automatic logic [31:0] faulty(input logic [31:0] v, input logic [AW-1:0] a);
    logic [31:0] r;
    r = v;
    if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  // SRAM model: one-cycle read latency, byte-masked writes
  logic [31:0] mem [DEPTH];
  always @(posedge clk) begin
    if (!csb0 && !web0) begin
      for (int b = 0; b < 4; b++)
        if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
    end
    if (!csb0 && web0) dout0 <= faulty(mem[addr0], addr0);
  end

  // Reference model
  typedef struct {
    logic          csb;
    logic          web;
    logic [AW-1:0] addr;
    logic [31:0]   din;
  } op_t;

  op_t           q[$];
  int            exp_cnt;
  logic [AW-1:0] exp_addr;
  logic [2:0]    exp_elem;
  logic [31:0]   exp_data;

  task automatic build_model(input logic [31:0] pat, input logic stp);
    logic [31:0]   rm [DEPTH];
    logic [31:0]   got, expv, wv;
    logic [AW-1:0] a;
    bit            stopped;
    op_t           op;
    q.delete();
    exp_cnt = 0; exp_addr = '0; exp_elem = 3'd0; exp_data = 32'd0;
    stopped = 0;
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (!stopped) begin
          a = (e == 3 || e == 4) ? AW'(DEPTH - 1 - j) : AW'(j);
          if (e != 0) begin
            op.csb = 1'b0; op.web = 1'b1; op.addr = a; op.din = 32'd0;
            q.push_back(op);
            for (int w = 0; w < RD_LAT; w++) begin
              op.csb = 1'b1; op.web = 1'b1; op.addr = '0; op.din = 32'd0;
              q.push_back(op);
            end
            got  = faulty(rm[a], a);
            expv = (e == 2 || e == 4) ? ~pat : pat;
            if (got != expv) begin
              exp_cnt++;
              if (exp_cnt == 1) begin
                exp_addr = a; exp_elem = 3'(e); exp_data = got;
              end
              if (stp) stopped = 1;
            end
          end
          if (!stopped && e != 5) begin
            wv = (e == 1 || e == 3) ? ~pat : pat;
            op.csb = 1'b0; op.web = 1'b0; op.addr = a; op.din = wv;
            q.push_back(op);
            rm[a] = wv;
          end
        end
      end
    end
  endtask

  // Checking
  int n_vec = 0;
  int n_err = 0;
  int busy_cycles;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_fail_count", fail_count, 16'd0);
    chk("rst_fail_addr", fail_addr, '0);
    chk("rst_fail_elem", fail_elem, 3'd0);
    chk("rst_fail_data", fail_data, 32'd0);
    chk("rst_csb0", csb0, 1'b1);
    chk("rst_web0", web0, 1'b1);
    chk("rst_wmask0", wmask0, 4'h0);
    chk("rst_addr0", addr0, '0);
    chk("rst_din0", din0, 32'd0);
  endtask

  // Called at the negedge of the first busy cycle; returns at the negedge
  // of the first cycle after the run.
  task automatic trace_run();
    busy_cycles = 0;
    for (int i = 0; i < q.size(); i++) begin
      chk("busy", busy, 1'b1);
      if (busy) busy_cycles++;
      chk("csb0", csb0, q[i].csb);
      if (!q[i].csb) begin
        chk("web0", web0, q[i].web);
        chk("addr0", addr0, q[i].addr);
        chk("wmask0", wmask0, q[i].web ? 4'h0 : 4'hF);
        if (!q[i].web) chk("din0", din0, q[i].din);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_done();
    chk("done", done, 1'b1);
    chk("busy_end", busy, 1'b0);
    chk("csb0_done", csb0, 1'b1);
    chk("pass", pass, exp_cnt == 0);
    chk("fail_count", fail_count, 16'(exp_cnt));
    chk("fail_addr", fail_addr, exp_addr);
    chk("fail_elem", fail_elem, exp_elem);
    chk("fail_data", fail_data, exp_data);
  endtask

  task automatic run_case(input logic [31:0] pat, input logic stp);
    pattern = pat;
    stop_on_fail = stp;
    build_model(pat, stp);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    trace_run();
    check_done();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop_on_fail = 1'b0; pattern = 32'd0;
    fault_en = 1'b0; fault_addr = '0; fault_bit = 0; fault_val = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset = 1'b0;

    // Fault-free, all-zero background: 60 busy cycles, pass
    run_case(32'h0000_0000, 1'b0);
    chk("busy_cycles", busy_cycles,
        DEPTH + 4 * DEPTH * (2 + RD_LAT) + DEPTH * (1 + RD_LAT));
    chk("tp1_pass", pass, 1'b1);

    // Checkerboard background
    run_case(32'hA5A5_A5A5, 1'b0);
    chk("tp2_pass", pass, 1'b1);

    // Address 2 bit 0 stuck-at-1, no stop
    fault_en = 1'b1; fault_addr = 2'd2; fault_bit = 0; fault_val = 1'b1;
    run_case(32'h0000_0000, 1'b0);
    chk("tp3_count", fail_count, 16'd3);
    chk("tp3_addr", fail_addr, 2'd2);
    chk("tp3_elem", fail_elem, 3'd1);
    chk("tp3_data", fail_data, 32'h0000_0001);
    chk("tp3_pass", pass, 1'b0);

    // Same fault, stop at first miscompare
    run_case(32'h0000_0000, 1'b1);
    chk("tp4_count", fail_count, 16'd1);
    repeat (3) begin
      @(negedge clk);
      chk("tp4_csb0_hold", csb0, 1'b1);
      chk("tp4_done_hold", done, 1'b1);
    end
    fault_en = 1'b0;

    // Reset in the middle of E2, then a clean full run
    pattern = $urandom;
    stop_on_fail = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (18) @(negedge clk);
    chk("tp5_busy_before", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals();
    run_case($urandom, 1'b0);
    chk("tp5_busy_cycles", busy_cycles,
        DEPTH + 4 * DEPTH * (2 + RD_LAT) + DEPTH * (1 + RD_LAT));

    // start held high for a whole run: no restart while busy, restart after done
    fault_en = 1'b1; fault_addr = 2'd2; fault_bit = 0; fault_val = 1'b1;
    pattern = 32'h0000_0000;
    stop_on_fail = 1'b0;
    build_model(pattern, 1'b0);
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    trace_run();
    check_done();
    @(negedge clk);
    chk("tp6_restart_busy", busy, 1'b1);
    chk("tp6_restart_done", done, 1'b0);
    chk("tp6_restart_count", fail_count, 16'd0);
    chk("tp6_restart_web0", web0, 1'b0);
    chk("tp6_restart_addr0", addr0, 2'd0);
    start = 1'b0;
    trace_run();
    check_done();

    // Randomized runs
    for (int r = 0; r < 10; r++) begin
      fault_en   = 1'($urandom_range(0, 1));
      fault_addr = AW'($urandom_range(0, DEPTH - 1));
      fault_bit  = $urandom_range(0, 31);
      fault_val  = 1'($urandom_range(0, 1));
      run_case($urandom, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
